sfp_mul_pipe: RTL
=================

Name: sfp_mul_pipe

Overview:
- Pipelined, parametrised signed fixed-point (sfp) multiplier for the raytracer math datapath.
- Computes the full-precision product internally, then requantises it to an arbitrary output format. Requantisation uses selectable rounding and saturation, and flags overflow.
- Sits between sfp producers and consumers that use a valid/ready handshake, e.g. dot-product and intersection units. Supports full backpressure.

Parameters:
- IW1, 8, integer bits of operand a (incl. sign)
- QW1, 8, fractional bits of operand a
- IW2, 8, integer bits of operand b (incl. sign)
- QW2, 8, fractional bits of operand b
- OIW, 8, integer bits of result (incl. sign)
- OQW, 8, fractional bits of result
- STAGES, 2, pipeline depth in cycles, legal range 1..4
- ROUND, 1, 0 = truncate (floor), 1 = round half up (toward +inf)
- SAT, 1, 1 = clamp on overflow, 0 = wrap (two's complement)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  IW1+QW1  signed operand a
- in_b  in  IW2+QW2  signed operand b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OIW+OQW  signed requantised product
- out_ovf  out  1  result exceeded the output range (qualified by out_valid)

Behaviour:
- Elaboration checks, each giving $error:
  - STAGES outside 1..4.
  - OQW > QW1+QW2, since fractional widening is not supported.
- Reset:
  - Asynchronous: every stage valid bit, out_valid, out_data and out_ovf go to 0 immediately on rst high.
  - in_ready is 1 while rst is low and the pipeline is empty.
- Pipeline advance:
  - Global stall. en = ~out_valid | out_ready, and in_ready = en.
  - When en = 1, every stage shifts one step and stage 0 captures in_valid & in_ready.
  - When en = 0, all stages hold.
  - Bubbles are carried, not collapsed.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+STAGES if there is no stall.
- Throughput: 1 beat per cycle with out_ready held high.
- Ordering: strictly in order, with no loss or duplication under any out_ready pattern.
- Stage mapping:
  - Stage 1 registers the full product P, width W1+W2, in format Q(IW1+IW2).(QW1+QW2).
  - The last stage registers out_data and out_ovf.
  - Intermediate stages are register-only retiming.
  - With STAGES = 1, multiply and requantise happen in one cycle.
- Requantisation, with S = QW1+QW2-OQW:
  - ROUND = 1 and S > 0: R = (P + 2^(S-1)) >>> S, computed with one guard bit so rounding cannot wrap.
  - Otherwise: R = P >>> S (arithmetic shift).
  - Range check on R: MIN = -2^(OIW+OQW-1), MAX = 2^(OIW+OQW-1)-1.
  - In range: out_data = R and out_ovf = 0.
  - Out of range, SAT = 1: clamp to MAX or MIN, out_ovf = 1.
  - Out of range, SAT = 0: out_data = low OIW+OQW bits of R, out_ovf = 1.
  - If rounding pushes the value past MAX, that is treated as overflow.
- Output stability: while out_valid = 1 and out_ready = 0, out_data and out_ovf hold stable.
- Reset mid-operation: all in-flight beats are discarded, and nothing is emitted after rst falls until new input arrives.

Test Plan:
- Q4.4 x Q4.4 -> Q4.4, STAGES = 2: in_a = 0x18 (1.5), in_b = 0x24 (2.25) -> out_data = 0x36 (3.375) with out_ovf = 0, exactly 2 cycles after acceptance.
- Rounding, Q4.4, half-LSB product:
  - 0x01 x 0x08 -> 0x01 with ROUND = 1, and 0x00 with ROUND = 0.
  - 0xFF (-0.0625) x 0x08 -> 0x00 with ROUND = 1, and 0xFF with ROUND = 0.
- Overflow, Q4.4:
  - 0x7F x 0x7F -> 0x7F, ovf = 1 with SAT = 1; 0xF0, ovf = 1 with SAT = 0.
  - 0x80 x 0x80 (-8 x -8) -> 0x7F, ovf = 1 with SAT = 1.
- Backpressure:
  - Stream 8 back-to-back beats while out_ready is low for cycles 3-5.
  - in_ready falls once out_valid = 1 and out_ready = 0.
  - All 8 results emerge in order with no duplicates, and out_data is stable during the stall.
- Reset: assert rst with 2 beats in flight -> out_valid drops in the same cycle without waiting for a clock edge. After release, no stale beat appears, and the next input returns after STAGES cycles.
- Sweep STAGES 1..4 with random operands and random out_ready against a reference model -> bit-exact out_data and out_ovf, latency equal to STAGES.

Source files
------------

// File: rtl/sfp_mul_pipe_if.sv
// Valid/ready bus carrying the multiplier operands in and the requantised product out.
// The producer/consumer side uses master, the multiplier uses slave.
interface sfp_mul_pipe_if #(
    parameter int AW = 16,
    parameter int BW = 16,
    parameter int OW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/sfp_mul_pipe.sv
// Pipelined signed fixed-point multiplier with requantisation (round/saturate/overflow flag).
// A single global stall freezes every stage; bubbles travel with the data.
module sfp_mul_pipe #(
    parameter int IW1    = 8,
    parameter int QW1    = 8,
    parameter int IW2    = 8,
    parameter int QW2    = 8,
    parameter int OIW    = 8,
    parameter int OQW    = 8,
    parameter int STAGES = 2,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic            clk,
    input  logic            rst,
    sfp_mul_pipe_if.slave   bus
);
    localparam int AW = IW1 + QW1;
    localparam int BW = IW2 + QW2;
    localparam int PW = AW + BW;
    localparam int OW = OIW + OQW;
    localparam int S  = QW1 + QW2 - OQW;
    localparam int SH = (S > 0) ? S : 0;
    localparam int RND_S = (S > 0) ? S - 1 : 0;
    // Working width keeps a guard bit above the product so the rounding add never wraps.
    localparam int XW = (PW + 2 > OW + 1) ? PW + 2 : OW + 1;

    localparam logic signed [XW-1:0] HALF = (ROUND != 0 && S > 0) ? (XW'(1) << RND_S) : '0;
    localparam logic signed [XW-1:0] MAXV = (XW'(1) << (OW - 1)) - XW'(1);
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("sfp_mul_pipe: STAGES must be in 1..4");
    end
    if (OQW > QW1 + QW2) begin : g_bad_oqw
        $error("sfp_mul_pipe: OQW wider than QW1+QW2 is not supported");
    end

    logic signed [AW-1:0] a_s;
    logic signed [BW-1:0] b_s;
    logic signed [PW-1:0] prod;
    logic                 en;
    logic                 out_valid_q;
    logic [OW-1:0]        out_data_q;
    logic                 out_ovf_q;

    assign a_s  = bus.in_a;
    assign b_s  = bus.in_b;
    assign prod = PW'(a_s) * PW'(b_s);

    assign en            = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

    // Returns {ovf, data} for a full-precision product.
    function automatic logic [OW:0] requant(input logic signed [PW-1:0] p);
        logic signed [XW-1:0] px;
        logic signed [XW-1:0] rx;
        logic [OW-1:0]        d;
        logic                 ovf;
        px = {{(XW-PW){p[PW-1]}}, p};
        rx = (px + HALF) >>> SH;
        if (rx > MAXV) begin
            ovf = 1'b1;
            d   = (SAT != 0) ? MAXV[OW-1:0] : rx[OW-1:0];
        end else if (rx < MINV) begin
            ovf = 1'b1;
            d   = (SAT != 0) ? MINV[OW-1:0] : rx[OW-1:0];
        end else begin
            ovf = 1'b0;
            d   = rx[OW-1:0];
        end
        return {ovf, d};
    endfunction

    if (STAGES <= 1) begin : g_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_ovf_q   <= 1'b0;
            end else if (en) begin
                out_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    {out_ovf_q, out_data_q} <= requant(prod);
                end
            end
        end
    end else begin : g_multi
        localparam int PD = STAGES - 1;

        // Product stage followed by retiming registers; requantise on the way into the last stage.
        logic signed [PW-1:0] p_q [PD];
        logic [PD-1:0]        pv_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv_q        <= '0;
                for (int i = 0; i < PD; i++) begin
                    p_q[i] <= '0;
                end
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_ovf_q   <= 1'b0;
            end else if (en) begin
                pv_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    p_q[0] <= prod;
                end
                for (int i = 1; i < PD; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    if (pv_q[i-1]) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
                out_valid_q <= pv_q[PD-1];
                if (pv_q[PD-1]) begin
                    {out_ovf_q, out_data_q} <= requant(p_q[PD-1]);
                end
            end
        end
    end
endmodule
